// File: rtl/abr_ahb_defines_pkg.sv
// Shared AHB-Lite encodings, initiator FSM states and the request alignment helper.
package abr_ahb_defines_pkg;

  localparam logic ABR_H_OKAY  = 1'b0;
  localparam logic ABR_H_ERROR = 1'b1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    ERR,
    RESP
  } abr_ahb_mstr_state_e;

  // True when the transfer size exceeds the bus width or the address is not size-aligned.
  function automatic logic abr_ahb_misaligned(input logic [2:0] addr_lo,
                                              input logic [1:0] size,
                                              input logic [1:0] max_size);
    logic [2:0] mask;
    mask = 3'((4'd1 << size) - 4'd1);
    return (size > max_size) || ((addr_lo & mask) != 3'b000);
  endfunction

endpackage

// File: rtl/abr_ahb_mstr.sv
// Single-outstanding AHB-Lite initiator: one SINGLE transfer per valid/ready request.
// Define ABR_AHB_MSTR_ALIGN_CHECK_EN to reject misaligned/oversized requests locally.
module abr_ahb_mstr
  import abr_ahb_defines_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          hclk,
  input  logic          hreset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_size,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic          rsp_error,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] haddr,
  output logic [1:0]    htrans,
  output logic          hwrite,
  output logic [2:0]    hsize,
  output logic [2:0]    hburst,
  output logic [DW-1:0] hwdata,
  input  logic [DW-1:0] hrdata,
  input  logic          hready,
  input  logic          hresp
);

  localparam logic [1:0] MAX_SIZE = (DW == 64) ? 2'd3 : 2'd2;

  abr_ahb_mstr_state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          write_q, write_d;
  logic [1:0]    size_q, size_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          write_d = req_write;
          size_d  = req_size;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ADDR;
`ifdef ABR_AHB_MSTR_ALIGN_CHECK_EN
          if (abr_ahb_misaligned(req_addr[2:0], req_size, MAX_SIZE)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
`endif
        end
      end
      ADDR: begin
        if (hready) state_d = DATA;
      end
      DATA: begin
        // ERROR with hready already high is a slave protocol violation; finish as error at once.
        if (hresp == ABR_H_ERROR) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = hready ? RESP : ERR;
        end else if (hready) begin
          rdata_d = write_q ? '0 : hrdata;
          state_d = RESP;
        end
      end
      ERR: begin
        if (hready) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign htrans    = (state_q == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr     = addr_q;
  assign hwrite    = write_q;
  assign hsize     = {1'b0, size_q};
  assign hburst    = HBURST_SINGLE;
  assign hwdata    = wdata_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_error = rsp_valid & err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;

endmodule

// File: doc/abr_ahb_mstr.md
# abr_ahb_mstr

Single-outstanding AHB-Lite initiator that turns a simple valid/ready request from an internal engine into one AHB-Lite SINGLE transfer and returns the read data and transfer status as a one-cycle response pulse. It drives the manager side of the bus: address, control and write data out, HRDATA/HREADY/HRESP in. It interprets HRESP with ABR_H_OKAY/ABR_H_ERROR, including the two-cycle ERROR response.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width; 32 or 64 only

Ports:
- hclk  in  1  clock
- hreset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  AW  byte address
- req_size  in  2  log2 of bytes (0=byte … 3=dword)
- req_wdata  in  DW  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_error  out  1  transfer ended in error; valid with rsp_valid
- rsp_rdata  out  DW  read data; valid with rsp_valid
- haddr  out  AW  AHB address
- htrans  out  2  IDLE=2'b00 or NONSEQ=2'b10 only
- hwrite  out  1  AHB write
- hsize  out  3  {1'b0, req_size}
- hburst  out  3  constant SINGLE (3'b000)
- hwdata  out  DW  AHB write data
- hrdata  in  DW  AHB read data
- hready  in  1  transfer ready
- hresp  in  1  ABR_H_OKAY / ABR_H_ERROR

## Operation
- FSM states:
  - IDLE: req_ready=1, htrans=IDLE. On accept, register addr, write, size and wdata, then go to ADDR.
  - ADDR: htrans=NONSEQ with haddr, hwrite and hsize driven. Hold until hready=1 is sampled, then go to DATA.
  - DATA: htrans=IDLE and hwdata driven from the register.
    - hready=1, hresp=OKAY: capture hrdata (reads only) and go to RESP.
    - hready=0, hresp=ERROR: go to ERR.
    - hready=0, hresp=OKAY: wait state, stay in DATA.
  - ERR: wait for hready=1 (second cycle of the ERROR response), then go to RESP with the error flag set. htrans stays IDLE, so no new transfer is started during ERR.
  - RESP: rsp_valid=1 for one cycle, then go to IDLE.
- rsp_rdata:
  - Write response: 0.
  - Error response: 0.
  - Otherwise the captured hrdata.
- hresp=ERROR together with hready=1 in DATA (protocol violation) is treated as an error completion and goes directly to RESP.
- No response backpressure: the consumer must accept rsp_valid whenever it is pulsed.

## Timing
- Reset values: htrans=2'b00, haddr=0, hwrite=0, hsize=0, hwdata=0, hburst=0, rsp_valid=0, rsp_error=0, rsp_rdata=0. req_ready=1 (the FSM resets into IDLE).
- Zero-wait-state transfer: accept at cycle T, address phase T+1, data phase T+2 (hready=1), rsp_valid at T+3. req_ready=0 from T+1 through T+3 and =1 again at T+4.
- Each data-phase wait state adds one cycle. An ERROR response adds exactly one cycle over OKAY.
- Reset mid-transfer: all outputs return to reset values immediately, no response is issued, and the held request is lost.
- req_* inputs are sampled only on the accept cycle and may change freely afterwards.

## Configuration
- ABR_AHB_MSTR_ALIGN_CHECK_EN defined:
  - A request is rejected locally if it is misaligned (req_addr low req_size bits nonzero) or if req_size > log2(DW/8).
  - A rejected request is accepted with no bus activity (htrans stays IDLE) and produces rsp_valid=1, rsp_error=1 at T+1. req_ready returns at T+2.
- ABR_AHB_MSTR_ALIGN_CHECK_EN undefined: every request is issued unchanged on the bus.

## Structure
- abr_ahb_defines_pkg: add HTRANS_IDLE, HTRANS_NONSEQ, HBURST_SINGLE and the FSM state enum (IDLE, ADDR, DATA, ERR, RESP). Use the existing ABR_H_OKAY/ABR_H_ERROR.
- Single module with no sub-module; the alignment check is a small combinational function.

## Test plan
- Zero-wait read: req addr=0x1000, size=2; slave returns hrdata=0xDEADBEEF with hready=1 → NONSEQ at T+1, rsp_valid at T+3 with rdata=0xDEADBEEF, error=0.
- Write with 3 wait states: addr=0x2004, wdata=0xA5A5A5A5 → hwdata stable across all wait cycles, rsp_valid at T+6 with error=0, rdata=0.
- Two-cycle ERROR response on a read → htrans=IDLE in both error cycles, rsp_valid at T+4 with error=1, rdata=0.
- Back-to-back requests with req_valid held high → second accept at T+4, no overlap of transfers.
- hreset_n asserted during DATA → htrans=0 and rsp_valid=0 immediately, req_ready=1, no response after reset release.
- With ABR_AHB_MSTR_ALIGN_CHECK_EN, addr=0x1001, size=2 → no NONSEQ issued, rsp_valid at T+1 with error=1. Without the macro the same request is issued on the bus.
